// File: rtl/laser_scan_ctrl.sv
// ---------------------------------------------------------------------------
// laser_scan_ctrl
//
// Sequencer for the two-circle placement search. Walks every candidate
// centre of the 16x16 grid (x fastest, then y), hands each one to the shared
// coverage-count datapath over a valid/ready request, keeps the strictly
// best response of the pass and writes it into the circle being optimised.
// Passes alternate between circle 1 and circle 2 until two consecutive
// passes leave their circle where it was, or MAX_ITER passes have run.
//
// Parameters:
//   MAX_ITER   maximum passes per run (1..15)
//   CNT_W      coverage count width
//
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   START                 run start pulse (honoured only in IDLE)
//   REQ_VALID/REQ_READY   candidate request handshake
//   REQ_X, REQ_Y          candidate centre
//   REQ_SEL               circle under optimisation (0 = C1, 1 = C2)
//   RSP_VALID, RSP_COUNT  coverage result for the outstanding request
//   MASK_LATCH            datapath loads the winner's mask as exclusion mask
//   C1X, C1Y, C2X, C2Y    current circle centres
//   BUSY                  high whenever not IDLE
//   DONE                  one-cycle completion pulse
// ---------------------------------------------------------------------------
//  state    | meaning
//  ---------+------------------------------------------------------------
//  S_IDLE   | waiting for START; centres hold the last result
//  S_ISSUE  | REQ_VALID high for candidate idx, waiting for REQ_READY
//  S_WAIT   | request accepted, waiting for RSP_VALID
//  S_UPDATE | commit pass winner, pulse MASK_LATCH, decide next pass/end
//  S_FINISH | DONE pulse
// ---------------------------------------------------------------------------
module laser_scan_ctrl #(
    parameter int MAX_ITER = 8,
    parameter int CNT_W    = 7
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    output logic             REQ_VALID,
    input  logic             REQ_READY,
    output logic [3:0]       REQ_X,
    output logic [3:0]       REQ_Y,
    output logic             REQ_SEL,
    input  logic             RSP_VALID,
    input  logic [CNT_W-1:0] RSP_COUNT,
    output logic             MASK_LATCH,
    output logic [3:0]       C1X,
    output logic [3:0]       C1Y,
    output logic [3:0]       C2X,
    output logic [3:0]       C2Y,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [3:0] MAX_ITER_L = 4'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_UPDATE,
        S_FINISH
    } state_t;

    state_t state, state_nxt;

    logic [7:0]       idx, idx_nxt;
    logic             sel, sel_nxt;
    logic [3:0]       best_x, best_x_nxt;
    logic [3:0]       best_y, best_y_nxt;
    logic [CNT_W-1:0] best_cnt, best_cnt_nxt;
    logic [3:0]       pass_cnt, pass_cnt_nxt;
    logic [1:0]       stable_cnt, stable_cnt_nxt;
    logic [3:0]       c1x, c1x_nxt, c1y, c1y_nxt;
    logic [3:0]       c2x, c2x_nxt, c2y, c2y_nxt;
    logic             changed;

    logic             req_valid_q, mask_latch_q, busy_q, done_q;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath update
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        sel_nxt        = sel;
        best_x_nxt     = best_x;
        best_y_nxt     = best_y;
        best_cnt_nxt   = best_cnt;
        pass_cnt_nxt   = pass_cnt;
        stable_cnt_nxt = stable_cnt;
        c1x_nxt        = c1x;
        c1y_nxt        = c1y;
        c2x_nxt        = c2x;
        c2y_nxt        = c2y;
        changed        = 1'b0;

        case (state)
            S_IDLE: begin
                if (START) begin
                    c1x_nxt        = 4'd0;
                    c1y_nxt        = 4'd0;
                    c2x_nxt        = 4'd0;
                    c2y_nxt        = 4'd0;
                    pass_cnt_nxt   = 4'd0;
                    stable_cnt_nxt = 2'd0;
                    sel_nxt        = 1'b0;
                    idx_nxt        = 8'd0;
                    best_x_nxt     = 4'd0;
                    best_y_nxt     = 4'd0;
                    best_cnt_nxt   = '0;
                    state_nxt      = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // REQ_VALID is high for the whole of ISSUE
                if (REQ_READY) begin
                    state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (RSP_VALID) begin
                    // strict compare: on a tie the earlier candidate stays
                    if (RSP_COUNT > best_cnt) begin
                        best_x_nxt   = idx[3:0];
                        best_y_nxt   = idx[7:4];
                        best_cnt_nxt = RSP_COUNT;
                    end
                    if (idx == 8'hFF) begin
                        state_nxt = S_UPDATE;
                    end else begin
                        idx_nxt   = idx + 8'd1;
                        state_nxt = S_ISSUE;
                    end
                end
            end

            S_UPDATE: begin
                if (!sel) begin
                    changed = (best_x != c1x) || (best_y != c1y);
                    c1x_nxt = best_x;
                    c1y_nxt = best_y;
                end else begin
                    changed = (best_x != c2x) || (best_y != c2y);
                    c2x_nxt = best_x;
                    c2y_nxt = best_y;
                end
                pass_cnt_nxt   = pass_cnt + 4'd1;
                stable_cnt_nxt = changed ? 2'd0 : stable_cnt + 2'd1;
                if ((stable_cnt_nxt == 2'd2) || (pass_cnt_nxt == MAX_ITER_L)) begin
                    state_nxt = S_FINISH;
                end else begin
                    sel_nxt      = ~sel;
                    idx_nxt      = 8'd0;
                    best_x_nxt   = 4'd0;
                    best_y_nxt   = 4'd0;
                    best_cnt_nxt = '0;
                    state_nxt    = S_ISSUE;
                end
            end

            S_FINISH: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx        <= 8'd0;
            sel        <= 1'b0;
            best_x     <= 4'd0;
            best_y     <= 4'd0;
            best_cnt   <= '0;
            pass_cnt   <= 4'd0;
            stable_cnt <= 2'd0;
            c1x        <= 4'd0;
            c1y        <= 4'd0;
            c2x        <= 4'd0;
            c2y        <= 4'd0;
        end else begin
            idx        <= idx_nxt;
            sel        <= sel_nxt;
            best_x     <= best_x_nxt;
            best_y     <= best_y_nxt;
            best_cnt   <= best_cnt_nxt;
            pass_cnt   <= pass_cnt_nxt;
            stable_cnt <= stable_cnt_nxt;
            c1x        <= c1x_nxt;
            c1y        <= c1y_nxt;
            c2x        <= c2x_nxt;
            c2y        <= c2y_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Status outputs, registered from the next state so they are glitch-free
    // and aligned with the state they describe.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            req_valid_q  <= 1'b0;
            mask_latch_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            req_valid_q  <= (state_nxt == S_ISSUE);
            mask_latch_q <= (state_nxt == S_UPDATE);
            busy_q       <= (state_nxt != S_IDLE);
            done_q       <= (state_nxt == S_FINISH);
        end
    end

    assign REQ_VALID  = req_valid_q;
    assign REQ_X      = idx[3:0];
    assign REQ_Y      = idx[7:4];
    assign REQ_SEL    = sel;
    assign MASK_LATCH = mask_latch_q;
    assign C1X        = c1x;
    assign C1Y        = c1y;
    assign C2X        = c2x;
    assign C2Y        = c2y;
    assign BUSY       = busy_q;
    assign DONE       = done_q;

endmodule

// File: tb/tb_laser_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_laser_scan_ctrl
//
// Drives laser_scan_ctrl with a coverage-datapath model (scenario-dependent
// count function, optional backpressure, latency and spurious inputs).
// A reference model computes the expected centres after every pass, the
// pass count and the run length; these go into scoreboard queues that a
// separate monitor pops on MASK_LATCH and DONE.
// ---------------------------------------------------------------------------
module tb_laser_scan_ctrl;

    localparam int MAX_ITER = 8;
    localparam int CNT_W    = 7;

    logic             CLK       = 1'b0;
    logic             RST_N     = 1'b1;
    logic             START     = 1'b0;
    logic             REQ_READY = 1'b0;
    logic             RSP_VALID = 1'b0;
    logic [CNT_W-1:0] RSP_COUNT = '0;
    logic             REQ_VALID, REQ_SEL, MASK_LATCH, BUSY, DONE;
    logic [3:0]       REQ_X, REQ_Y, C1X, C1Y, C2X, C2Y;

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int start_cyc  = 0;
    int extra_cyc  = 0;
    int done_cnt   = 0;
    int done_cyc   = 0;
    int last_masks = 0;
    int mode       = 0;
    int rk         = 1;
    int rtab [3][256];

    // expected centres packed as {c1x,c1y,c2x,c2y} nibbles
    int pass_q [$];
    int fin_q  [$];
    int np_q   [$];

    laser_scan_ctrl #(.MAX_ITER(MAX_ITER), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .START      (START),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_X      (REQ_X),
        .REQ_Y      (REQ_Y),
        .REQ_SEL    (REQ_SEL),
        .RSP_VALID  (RSP_VALID),
        .RSP_COUNT  (RSP_COUNT),
        .MASK_LATCH (MASK_LATCH),
        .C1X        (C1X),
        .C1Y        (C1Y),
        .C2X        (C2X),
        .C2Y        (C2Y),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pk(input int a, input int b, input int c, input int d);
        return a * 4096 + b * 256 + c * 16 + d;
    endfunction

    function automatic int cents();
        return int'({C1X, C1Y, C2X, C2Y});
    endfunction

    function automatic int all_outs();
        return int'({REQ_VALID, REQ_SEL, REQ_X, REQ_Y, MASK_LATCH,
                     C1X, C1Y, C2X, C2Y, BUSY, DONE});
    endfunction

    // coverage count returned by the datapath model for pass p (0-based)
    function automatic int cov(input int p, input int x, input int y);
        int v;
        v = 0;
        case (mode)
            0:       v = ((x == 9 && y == 2) || (x == 5 && y == 7)) ? 3 : 0;
            1:       v = (x == p && y == p) ? 10 : 1;
            default: v = rtab[p % rk][y * 16 + x];
        endcase
        return v;
    endfunction

    // reference: the search algorithm expressed directly over the grid
    task automatic build_expect();
        int cx [2];
        int cy [2];
        int stable, bx, by, bc, v, np, s, e;
        cx[0] = 0; cx[1] = 0; cy[0] = 0; cy[1] = 0;
        stable = 0; np = 0; e = 0;
        for (int p = 0; p < MAX_ITER; p++) begin
            s  = p % 2;
            bx = 0; by = 0; bc = 0;
            for (int y = 0; y < 16; y++) begin
                for (int x = 0; x < 16; x++) begin
                    v = cov(p, x, y);
                    if (v > bc) begin
                        bc = v; bx = x; by = y;
                    end
                end
            end
            stable = (bx == cx[s] && by == cy[s]) ? stable + 1 : 0;
            cx[s] = bx; cy[s] = by;
            np = p + 1;
            e = pk(cx[0], cy[0], cx[1], cy[1]);
            pass_q.push_back(e);
            if (stable == 2) break;
        end
        fin_q.push_back(e);
        np_q.push_back(np);
    endtask

    task automatic flush_expect();
        pass_q.delete();
        fin_q.delete();
        np_q.delete();
    endtask

    // reset pulse asserted between clock edges; checks outputs clear at once
    task automatic mid_reset(input string tag);
        #2;
        RST_N = 1'b0;
        START = 1'b0; REQ_READY = 1'b0; RSP_VALID = 1'b0;
        #1;
        chk({tag, "_async_outs"}, all_outs(), 0);
        flush_expect();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk({tag, "_busy_after"}, int'(BUSY), 0);
        chk({tag, "_centres_after"}, cents(), 0);
    endtask

    // one run: m = scenario, bp37 = stall/latency at idx 37, rnd = random
    // ready/latency, spur = spurious START/RSP_VALID, abort_hs = request
    // number at which reset is pulsed (-1 for none)
    task automatic run(input int m, input bit bp37, input bit rnd, input bit spur,
                       input int abort_hs);
        int  hs, lat, pcnt, bp_left, budget, done_base, dens, exp_req;
        bit  pending, ready;
        mode = m;
        if (m == 2) begin
            rk   = int'($urandom_range(1, 3));
            dens = int'($urandom_range(0, 3));
            for (int t = 0; t < 3; t++)
                for (int i = 0; i < 256; i++)
                    rtab[t][i] = (int'($urandom_range(0, 3)) < dens) ?
                                 int'($urandom_range(0, 20)) : 0;
        end
        hs = 0; lat = 0; pcnt = 0; bp_left = 0; budget = 0; pending = 0;
        extra_cyc = 0;
        build_expect();
        done_base = done_cnt;
        @(negedge CLK);
        START     = 1'b1;
        start_cyc = cyc + 1;
        while (done_cnt == done_base) begin
            if (budget > 40000) begin
                checks++; errors++;
                $display("FAIL run_timeout mode=%0d requests=%0d actual=no_done required=done", m, hs);
                mid_reset("timeout");
                break;
            end
            budget++;
            @(negedge CLK);
            START = 1'b0; RSP_VALID = 1'b0; REQ_READY = 1'b0;
            if (pending) begin
                if (lat == 0) begin
                    RSP_VALID = 1'b1;
                    RSP_COUNT = CNT_W'(pcnt);
                    pending   = 0;
                end else begin
                    lat--;
                    extra_cyc++;
                end
                if (spur && $urandom_range(0, 15) == 0) START = 1'b1;
            end else if (REQ_VALID) begin
                if (abort_hs >= 0 && hs == abort_hs) begin
                    mid_reset("abort");
                    break;
                end
                if (bp37 && hs == 37 && bp_left < 5) begin
                    chk("bp_hold_req", int'({REQ_VALID, REQ_Y, REQ_X}), 'h125);
                    bp_left++;
                    ready = 0;
                end else begin
                    ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (spur && $urandom_range(0, 7) == 0) begin
                    RSP_VALID = 1'b1;
                    RSP_COUNT = 7'd40;
                end
                if (ready) begin
                    REQ_READY = 1'b1;
                    exp_req = ((hs / 256) % 2) * 256 + ((hs / 16) % 16) * 16 + (hs % 16);
                    chk("req_sel_y_x", int'({REQ_SEL, REQ_Y, REQ_X}), exp_req);
                    pcnt    = cov(hs / 256, int'(REQ_X), int'(REQ_Y));
                    lat     = (bp37 && hs == 37) ? 3 : (rnd ? int'($urandom_range(0, 3)) : 0);
                    pending = 1;
                    hs++;
                end else begin
                    extra_cyc++;
                end
            end
        end
        START = 1'b0; REQ_READY = 1'b0; RSP_VALID = 1'b0;
    endtask

    // monitor / scoreboard
    initial begin : monitor
        bit mask_prev, done_prev;
        int mask_run, e, np;
        mask_prev = 0; done_prev = 0; mask_run = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (!RST_N) begin
                mask_prev = 0; done_prev = 0; mask_run = 0;
                continue;
            end
            if (mask_prev) begin
                if (pass_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pass_unexpected actual=mask_latch required=none");
                end else begin
                    e = pass_q.pop_front();
                    chk("pass_centres", cents(), e);
                end
            end
            if (done_prev) begin
                chk("idle_after_finish", int'({BUSY, DONE}), 0);
            end
            if (MASK_LATCH) mask_run++;
            if (DONE) begin
                chk("busy_in_finish", int'(BUSY), 1);
                if (fin_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected actual=done required=none");
                end else begin
                    e  = fin_q.pop_front();
                    np = np_q.pop_front();
                    chk("final_centres", cents(), e);
                    chk("pass_count", mask_run, np);
                    chk("done_edges", cyc - start_cyc, 513 * np + extra_cyc);
                end
                last_masks = mask_run;
                done_cyc   = cyc;
                mask_run   = 0;
                done_cnt++;
            end
            mask_prev = MASK_LATCH;
            done_prev = DONE;
        end
    end

    initial begin : main
        #2;
        RST_N = 1'b0;
        #1;
        chk("reset_outputs", all_outs(), 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("reset_busy", int'(BUSY), 0);

        run(0, 0, 0, 0, -1);
        chk("tie_centres", cents(), 'h9292);
        chk("tie_done_edges", done_cyc - start_cyc, 2052);
        chk("tie_mask_pulses", last_masks, 4);
        repeat (4) @(negedge CLK);
        chk("hold_after_done", cents(), 'h9292);
        chk("idle_outputs", int'({BUSY, DONE, REQ_VALID, MASK_LATCH}), 0);

        run(0, 1, 0, 1, -1);
        chk("bp_centres", cents(), 'h9292);
        chk("bp_done_edges", done_cyc - start_cyc, 2060);

        run(1, 0, 0, 1, -1);
        chk("cap_centres", cents(), 'h6677);
        chk("cap_mask_pulses", last_masks, 8);

        run(0, 0, 0, 0, 256 + 100);

        for (int r = 0; r < 4; r++) begin
            run(2, 0, 1, 1, -1);
        end

        repeat (3) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
